start_screen_sequencer: RTL
===========================

// Module: start_screen_sequencer
// PURPOSE
//  Sequences the start-screen image path. Maps VGA pixel coordinates to the start-image
//  ROM address and aligns the ROM colour index with display timing. Drives is_b, the
//  palette-swap select of start_color_decoder.
//  Runs a small title FSM: idle blink, then "press start" flash, then done handoff to game.
// PARAMETERS
//  IMG_W        160  image width in ROM pixels
//  IMG_H        120  image height in ROM pixels
//  SCALE_SHIFT  2    screen-to-image downscale (log2); 640x480 -> 160x120
//  ADDR_W       15   ROM address width; must satisfy 2**ADDR_W >= IMG_W*IMG_H
//  BLINK_FRAMES 30   frames per is_b toggle in IDLE
//  FLASH_RATE   4    frames per is_b toggle in FLASH
//  FLASH_FRAMES 90   total frames spent in FLASH
// PORTS
//  clk                in   1       pixel clock
//  rst                in   1       asynchronous reset, active-high
//  h_cnt              in   10      VGA horizontal pixel counter
//  v_cnt              in   10      VGA vertical line counter
//  valid              in   1       display-enable for (h_cnt,v_cnt)
//  frame_tick         in   1       1-cycle pulse, once per frame (start of vblank)
//  start_btn          in   1       debounced 1-cycle press pulse
//  rom_addr           out  ADDR_W  address to start-image ROM (sync ROM, 1-cycle read)
//  rom_data           in   4       colour index from ROM, valid 1 cycle after rom_addr
//  start_color_index  out  4       colour index to decoder
//  is_b               out  1       palette select to decoder
//  pix_valid          out  1       valid delayed to align with start_color_index
//  pix_opaque         out  1       high when the pixel is drawn (not transparent)
//  start_done         out  1       high once the title sequence is finished
// BEHAVIOUR
//  Reset: rom_addr=0, start_color_index=0, is_b=0, pix_valid=0, pix_opaque=0,
//   start_done=0, FSM=IDLE, frame counter=0. All pipeline registers are cleared.
//  Address: ix=h_cnt>>SCALE_SHIFT, iy=v_cnt>>SCALE_SHIFT.
//   rom_addr <= iy*IMG_W+ix, registered at edge 1. The product is computed at full width,
//   then truncated to ADDR_W. If ix>=IMG_W, iy>=IMG_H or !valid, then rom_addr<=0 and the
//   in-image flag is cleared.
//  Pipeline: total latency is 3 cycles from h/v/valid to outputs.
//   Edge 1: rom_addr.
//   Edge 2: ROM data arrives. The in-image and valid flags are delayed to match.
//   Edge 3: start_color_index <= in_img ? rom_data : 0; pix_valid <= valid delayed 3.
//  FSM (advances only on frame_tick, except for start_btn):
//   IDLE:  is_b toggles every BLINK_FRAMES ticks.
//          start_btn -> FLASH, counter cleared, is_b<=1.
//   FLASH: is_b toggles every FLASH_RATE ticks.
//          After FLASH_FRAMES ticks -> DONE.
//   DONE:  is_b<=0, start_done<=1 and held until rst.
//  Boundary conditions:
//   - start_btn and frame_tick in the same cycle: start_btn wins; counter = 0, not 1.
//   - start_btn in FLASH or DONE is ignored (but see START_SKIP_EN).
//   - The counter wraps to 0 at each toggle point; it never exceeds FLASH_FRAMES-1.
//   - rst mid-FLASH returns immediately to IDLE with all outputs at reset values.
//   - is_b changes only on a clock edge after frame_tick. It never changes mid-frame
//     except in response to start_btn.
// CONFIGURATION
//  START_SKIP_EN defined: start_btn in FLASH -> DONE on the next edge (skips the flash).
//  START_SKIP_EN undefined: start_btn in FLASH is ignored; FLASH always lasts FLASH_FRAMES.
// STRUCTURE
//  start_pkg:
//   - FSM state encoding ST_IDLE=2'd0, ST_FLASH=2'd1, ST_DONE=2'd2
//   - COLOR_TRANSPARENT=4'd0
//   - default IMG_W/IMG_H constants
//  Sub-module start_blink_timer: frame counter plus toggle output.
//   Inputs: frame_tick, clear, period. Output: 1-cycle toggle strobe.
//   Instantiated once; period is muxed by FSM state.
//  pix_opaque = pix_valid && (start_color_index != COLOR_TRANSPARENT), registered at edge 3.
// TESTING
//  1. h=8,v=4,valid=1, ROM model returns addr[3:0]:
//     rom_addr=1*160+2=162 at cycle 1; start_color_index=4'd2, pix_valid=1 at cycle 3.
//  2. h=640,v=0,valid=1: rom_addr=0, start_color_index=0, pix_opaque=0 at cycle 3.
//     Likewise for valid=0 anywhere on screen: pix_valid=0.
//  3. IDLE, 60 frame_ticks: is_b toggles after tick 30 and tick 60, ending at 0.
//  4. start_btn coincident with frame_tick: is_b=1 next cycle. The first FLASH toggle
//     occurs on the 4th tick after.
//  5. FSM reaches DONE after 90 ticks: start_done=1, is_b=0; further start_btn has no
//     effect. With START_SKIP_EN, start_btn at FLASH tick 10 -> start_done=1 next cycle.
//  6. Assert rst mid-FLASH for 1 cycle: all outputs are 0 immediately (async); IDLE blink
//     resumes from count 0.

Source files
------------

// File: rtl/start_screen_sequencer_pkg.sv
// start_pkg: shared FSM encoding, colour constants and default image geometry
package start_pkg;
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FLASH = 2'd1,
    ST_DONE  = 2'd2
  } state_t;
  localparam logic [3:0] COLOR_TRANSPARENT = 4'd0;
  localparam int IMG_W_DEF = 160;
  localparam int IMG_H_DEF = 120;
  localparam int ADDR_W_DEF = 15;
endpackage

// File: rtl/start_screen_sequencer_if.sv
// start_screen_sequencer_if: pixel, ROM and title-sequence signals of the start screen
interface start_screen_sequencer_if #(parameter int ADDR_W = 15);
  logic [9:0]        i_h_cnt;
  logic [9:0]        i_v_cnt;
  logic              i_valid;
  logic              i_frame_tick;
  logic              i_start_btn;
  logic [ADDR_W-1:0] o_rom_addr;
  logic [3:0]        i_rom_data;
  logic [3:0]        o_start_color_index;
  logic              o_is_b;
  logic              o_pix_valid;
  logic              o_pix_opaque;
  logic              o_start_done;
  modport slave (
    input  i_h_cnt, i_v_cnt, i_valid, i_frame_tick, i_start_btn, i_rom_data,
    output o_rom_addr, o_start_color_index, o_is_b, o_pix_valid, o_pix_opaque, o_start_done
  );
  modport master (
    output i_h_cnt, i_v_cnt, i_valid, i_frame_tick, i_start_btn, i_rom_data,
    input  o_rom_addr, o_start_color_index, o_is_b, o_pix_valid, o_pix_opaque, o_start_done
  );
endinterface

// File: rtl/start_screen_sequencer_blink_timer.sv
// start_blink_timer: frame counter that strobes once every i_period frame ticks
module start_blink_timer #(parameter int W = 8) (
  input  logic         clk,
  input  logic         rst,
  input  logic         i_tick,
  input  logic         i_clear,
  input  logic [W-1:0] i_period,
  output logic         o_toggle
);
  logic [W-1:0] r_cnt;
  logic         w_wrap;
  assign w_wrap   = r_cnt == i_period - W'(1);
  assign o_toggle = i_tick && !i_clear && w_wrap;
  always_ff @(posedge clk or posedge rst)
    if (rst) r_cnt <= '0;
    else if (i_clear) r_cnt <= '0;
    else if (i_tick) r_cnt <= w_wrap ? '0 : r_cnt + W'(1);
endmodule

// File: rtl/start_screen_sequencer.sv
// start_screen_sequencer: start-image address/colour pipeline plus title blink/flash FSM
// START_SKIP_EN: when defined, start_btn during FLASH jumps straight to DONE.
module start_screen_sequencer
  import start_pkg::*;
#(
  parameter int IMG_W        = IMG_W_DEF,
  parameter int IMG_H        = IMG_H_DEF,
  parameter int SCALE_SHIFT  = 2,
  parameter int ADDR_W       = ADDR_W_DEF,
  parameter int BLINK_FRAMES = 30,
  parameter int FLASH_RATE   = 4,
  parameter int FLASH_FRAMES = 90
) (
  input logic clk,
  input logic rst,
  start_screen_sequencer_if.slave bus
);
  localparam int FCNT_W = $clog2(FLASH_FRAMES);
  localparam logic [31:0] IMG_W_U = IMG_W;
  localparam logic [31:0] IMG_H_U = IMG_H;
  logic [31:0]       w_ix, w_iy;
  logic              w_in;
  logic [ADDR_W-1:0] w_addr;
  logic [3:0]        w_color;
  logic [ADDR_W-1:0] r_rom_addr;
  logic              r_in1, r_in2, r_v1, r_v2;
  logic [3:0]        r_color;
  logic              r_pv, r_op;
  assign w_ix    = 32'(bus.i_h_cnt >> SCALE_SHIFT);
  assign w_iy    = 32'(bus.i_v_cnt >> SCALE_SHIFT);
  assign w_in    = bus.i_valid && w_ix < IMG_W_U && w_iy < IMG_H_U;
  assign w_addr  = ADDR_W'(w_iy * IMG_W_U + w_ix);
  assign w_color = r_in2 ? bus.i_rom_data : COLOR_TRANSPARENT;
  // Flags ride alongside the sync ROM so they line up with its read data.
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      r_rom_addr <= '0;
      r_in1      <= 1'b0;
      r_in2      <= 1'b0;
      r_v1       <= 1'b0;
      r_v2       <= 1'b0;
      r_color    <= COLOR_TRANSPARENT;
      r_pv       <= 1'b0;
      r_op       <= 1'b0;
    end else begin
      r_rom_addr <= w_in ? w_addr : '0;
      r_in1      <= w_in;
      r_in2      <= r_in1;
      r_v1       <= bus.i_valid;
      r_v2       <= r_v1;
      r_color    <= w_color;
      r_pv       <= r_v2;
      r_op       <= r_v2 && w_color != COLOR_TRANSPARENT;
    end
  state_t            r_state, w_state_n;
  logic              r_is_b, w_is_b_n;
  logic              r_done, w_done_n;
  logic [FCNT_W-1:0] r_fcnt, w_fcnt_n;
  logic              w_clear, w_toggle, w_skip, w_finish;
  logic [7:0]        w_period;
`ifdef START_SKIP_EN
  assign w_skip = bus.i_start_btn;
`else
  assign w_skip = 1'b0;
`endif
  assign w_period = r_state == ST_IDLE ? 8'(BLINK_FRAMES) : 8'(FLASH_RATE);
  assign w_finish = w_skip || (bus.i_frame_tick && r_fcnt == FCNT_W'(FLASH_FRAMES - 1));
  start_blink_timer #(.W(8)) u_timer (
    .clk      (clk),
    .rst      (rst),
    .i_tick   (bus.i_frame_tick),
    .i_clear  (w_clear),
    .i_period (w_period),
    .o_toggle (w_toggle)
  );
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      r_state <= ST_IDLE;
      r_is_b  <= 1'b0;
      r_done  <= 1'b0;
      r_fcnt  <= '0;
    end else begin
      r_state <= w_state_n;
      r_is_b  <= w_is_b_n;
      r_done  <= w_done_n;
      r_fcnt  <= w_fcnt_n;
    end
  // start_btn is checked before frame_tick so a coincident press restarts the count at 0.
  always_comb begin
    w_state_n = r_state;
    w_is_b_n  = r_is_b;
    w_done_n  = r_done;
    w_fcnt_n  = r_fcnt;
    w_clear   = 1'b0;
    case (r_state)
      ST_IDLE:
        if (bus.i_start_btn) begin
          w_state_n = ST_FLASH;
          w_clear   = 1'b1;
          w_is_b_n  = 1'b1;
          w_fcnt_n  = '0;
        end else if (w_toggle) w_is_b_n = ~r_is_b;
      ST_FLASH:
        if (w_finish) begin
          w_state_n = ST_DONE;
          w_is_b_n  = 1'b0;
          w_done_n  = 1'b1;
        end else if (bus.i_frame_tick) begin
          w_fcnt_n = r_fcnt + FCNT_W'(1);
          w_is_b_n = w_toggle ? ~r_is_b : r_is_b;
        end
      ST_DONE: begin
        w_is_b_n = 1'b0;
        w_done_n = 1'b1;
      end
      default: w_state_n = ST_IDLE;
    endcase
  end
  assign bus.o_rom_addr          = r_rom_addr;
  assign bus.o_start_color_index = r_color;
  assign bus.o_is_b              = r_is_b;
  assign bus.o_pix_valid         = r_pv;
  assign bus.o_pix_opaque        = r_op;
  assign bus.o_start_done        = r_done;
endmodule
